// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer, the fetch unit and decode.
// Signal names carry their direction as seen from the sequencer.
interface fetch_sequencer_if #(
    parameter int XLEN      = 32,
    parameter int IMDATALEN = 32
);
    logic                 o_fetch_valid;
    logic                 i_fetch_ready;
    logic [XLEN-1:0]      o_fetch_addr;
    logic                 i_instr_valid;
    logic                 o_instr_ready;
    logic [IMDATALEN-1:0] i_instr_data;
    logic                 i_redirect_valid;
    logic [XLEN-1:0]      i_redirect_pc;
    logic                 o_dec_valid;
    logic                 i_dec_ready;
    logic [IMDATALEN-1:0] o_dec_instr;
    logic [XLEN-1:0]      o_dec_pc;

    modport master (
        output o_fetch_valid, o_fetch_addr, o_instr_ready,
        output o_dec_valid, o_dec_instr, o_dec_pc,
        input  i_fetch_ready, i_instr_valid, i_instr_data,
        input  i_redirect_valid, i_redirect_pc, i_dec_ready
    );

    modport slave (
        input  o_fetch_valid, o_fetch_addr, o_instr_ready,
        input  o_dec_valid, o_dec_instr, o_dec_pc,
        output i_fetch_ready, i_instr_valid, i_instr_data,
        output i_redirect_valid, i_redirect_pc, i_dec_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter owner for instruction fetch: issues word-aligned reads, tags them
// with PC and epoch, drops responses made stale by a redirect and feeds decode.
module fetch_sequencer #(
    parameter int              XLEN            = 32,
    parameter int              IMDATALEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic               clk,
    input  logic               rstn,
    fetch_sequencer_if.master  bus
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W:0]   MAX_CNT  = (CNT_W + 1)'(MAX_OUTSTANDING);
    localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(32'd4);
    localparam logic [XLEN-1:0]  PC_MASK  = ~(XLEN'(32'd3));

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                state_q;
    logic [XLEN-1:0]       pc_q;
    logic                  epoch_q;
    logic                  ar_valid_q;
    logic [XLEN-1:0]       ar_addr_q;
    logic                  ar_epoch_q;
    logic [XLEN-1:0]       tag_pc_q [MAX_OUTSTANDING];
    logic                  tag_ep_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  dec_valid_q;
    logic [IMDATALEN-1:0]  dec_instr_q;
    logic [XLEN-1:0]       dec_pc_q;

    logic                  ar_hs;
    logic                  r_hs;
    logic                  fifo_ne;
    logic                  head_stale;
    logic                  instr_ready;
    logic                  issue;
    logic [CNT_W:0]        in_flight;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? {PTR_W{1'b0}} : (p + PTR_ONE);
    endfunction

    // Handshake detection, staleness of the oldest tag and the issue decision.
    always_comb begin
        ar_hs       = ar_valid_q & bus.i_fetch_ready;
        fifo_ne     = (count_q != {CNT_W{1'b0}});
        head_stale  = (tag_ep_q[rd_ptr_q] != epoch_q) | bus.i_redirect_valid;
        instr_ready = fifo_ne & (head_stale | ~dec_valid_q | bus.i_dec_ready);
        r_hs        = bus.i_instr_valid & instr_ready;
        in_flight   = {1'b0, count_q} + {{CNT_W{1'b0}}, ar_valid_q};
        issue       = (state_q == ST_RUN) & ~bus.i_redirect_valid &
                      (~ar_valid_q | ar_hs) & (in_flight < MAX_CNT);
        case ({ar_hs, r_hs})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Sequencer state: FSM, PC/epoch, AR register, tag FIFO and decode stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            epoch_q     <= 1'b0;
            ar_valid_q  <= 1'b0;
            ar_addr_q   <= RESET_PC;
            ar_epoch_q  <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_pc_q[i] <= {XLEN{1'b0}};
                tag_ep_q[i] <= 1'b0;
            end
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            dec_valid_q <= 1'b0;
            dec_instr_q <= {IMDATALEN{1'b0}};
            dec_pc_q    <= {XLEN{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: state_q <= ST_RUN;
                ST_RUN:  state_q <= ST_RUN;
                default: state_q <= ST_IDLE;
            endcase

            // A redirect wins over sequential issue; the epoch flip makes every older tag stale.
            if (bus.i_redirect_valid) begin
                pc_q    <= bus.i_redirect_pc & PC_MASK;
                epoch_q <= ~epoch_q;
            end else if (issue) begin
                pc_q    <= pc_q + PC_STEP;
            end

            if (issue) begin
                ar_valid_q <= 1'b1;
                ar_addr_q  <= pc_q;
                ar_epoch_q <= epoch_q;
            end else if (ar_hs) begin
                ar_valid_q <= 1'b0;
            end

            if (ar_hs) begin
                tag_pc_q[wr_ptr_q] <= ar_addr_q;
                tag_ep_q[wr_ptr_q] <= ar_epoch_q;
                wr_ptr_q           <= ptr_inc(wr_ptr_q);
            end
            if (r_hs) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;

            if (bus.i_redirect_valid) begin
                dec_valid_q <= 1'b0;
            end else if (r_hs && !head_stale) begin
                dec_valid_q <= 1'b1;
                dec_instr_q <= bus.i_instr_data;
                dec_pc_q    <= tag_pc_q[rd_ptr_q];
            end else if (bus.i_dec_ready) begin
                dec_valid_q <= 1'b0;
            end
        end
    end

    assign bus.o_fetch_valid = ar_valid_q;
    assign bus.o_fetch_addr  = ar_addr_q;
    assign bus.o_instr_ready = instr_ready;
    assign bus.o_dec_valid   = dec_valid_q;
    assign bus.o_dec_instr   = dec_instr_q;
    assign bus.o_dec_pc      = dec_pc_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a transaction-level memory and decode model
// predicts the fetch address stream, which responses survive and what decode sees.
module tb_fetch_sequencer;
    localparam int          MAX_OUT = 2;
    localparam logic [31:0] RST_PC  = 32'h0000_0100;

    logic clk;
    logic rstn;

    fetch_sequencer_if #(.XLEN(32), .IMDATALEN(32)) bus ();

    fetch_sequencer #(
        .XLEN(32), .IMDATALEN(32), .RESET_PC(RST_PC), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: memory holds accepted requests (address + redirect generation).
    logic [31:0] mem_addr_q[$];
    int          mem_gen_q[$];
    logic [31:0] exp_dpc[$];
    logic [31:0] exp_dins[$];
    int          redirect_cnt;
    logic [31:0] exp_pc;
    bit          ar_seen;
    logic [31:0] ar_held;
    int          ar_gen;
    logic [31:0] prev_appear;
    bit          seen_wrap;
    int          cyc, first_valid, n_ar, n_dec;

    int          p_frdy, p_ivld, p_drdy, p_redir;
    bit          force_redir;
    logic [31:0] force_tgt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // A redirect is only generated when nothing from an older generation is still in flight.
    function automatic bit redirect_safe();
        foreach (mem_gen_q[i]) if (mem_gen_q[i] != redirect_cnt) return 1'b0;
        if (ar_seen && ar_gen != redirect_cnt) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.i_fetch_ready = 1'b0; bus.i_instr_valid = 1'b0; bus.i_instr_data = 32'h0;
        bus.i_redirect_valid = 1'b0; bus.i_redirect_pc = 32'h0; bus.i_dec_ready = 1'b0;
        mem_addr_q.delete(); mem_gen_q.delete(); exp_dpc.delete(); exp_dins.delete();
        redirect_cnt = 0; exp_pc = RST_PC; ar_seen = 1'b0; ar_gen = 0;
        prev_appear = 32'h0; n_ar = 0; force_redir = 1'b0;
        #1;
        check_eq("rst_fetch_valid", bus.o_fetch_valid, 1'b0);
        check_eq("rst_fetch_addr",  bus.o_fetch_addr,  RST_PC);
        check_eq("rst_dec_valid",   bus.o_dec_valid,   1'b0);
        check_eq("rst_dec_instr",   bus.o_dec_instr,   32'h0);
        check_eq("rst_dec_pc",      bus.o_dec_pc,      32'h0);
        check_eq("rst_instr_ready", bus.o_instr_ready, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        cyc = 0; first_valid = -1;
    endtask

    task automatic step();
        bit fr, dr, rv, redir, stale, exp_rdy;
        logic [31:0] tgt, a;
        int g;
        @(negedge clk);
        cyc++;
        fr = ($urandom_range(0, 99) < p_frdy);
        dr = ($urandom_range(0, 99) < p_drdy);
        rv = (mem_addr_q.size() != 0) && ($urandom_range(0, 99) < p_ivld);
        if (force_redir) begin
            redir = 1'b1; tgt = force_tgt;
        end else begin
            redir = ($urandom_range(0, 99) < p_redir) && redirect_safe();
            tgt = $urandom;
        end
        bus.i_fetch_ready    = fr;
        bus.i_dec_ready      = dr;
        bus.i_instr_valid    = rv;
        bus.i_instr_data     = rv ? instr_of(mem_addr_q[0]) : $urandom;
        bus.i_redirect_valid = redir;
        bus.i_redirect_pc    = tgt;
        #1;
        // Decode stage content versus the model's one-entry queue.
        check_eq("dec_valid", bus.o_dec_valid, exp_dpc.size() != 0);
        if (exp_dpc.size() != 0 && bus.o_dec_valid) begin
            check_eq("dec_pc",    bus.o_dec_pc,    exp_dpc[0]);
            check_eq("dec_instr", bus.o_dec_instr, exp_dins[0]);
        end
        exp_rdy = 1'b0;
        stale   = 1'b0;
        if (mem_addr_q.size() != 0) begin
            stale   = (mem_gen_q[0] != redirect_cnt) || redir;
            exp_rdy = stale || (exp_dpc.size() == 0) || dr;
        end
        check_eq("instr_ready", bus.o_instr_ready, exp_rdy);
        // Fetch request stream: every new request is the next model PC; held ones stay put.
        if (bus.o_fetch_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (!ar_seen) begin
                check_eq("fetch_addr", bus.o_fetch_addr, exp_pc);
                ar_held = exp_pc; ar_gen = redirect_cnt; ar_seen = 1'b1;
                if (ar_held == 32'h0 && prev_appear == 32'hFFFF_FFFC) seen_wrap = 1'b1;
                prev_appear = ar_held;
                exp_pc = exp_pc + 32'd4;
            end else begin
                check_eq("fetch_hold", bus.o_fetch_addr, ar_held);
            end
        end else if (ar_seen) begin
            check_eq("fetch_valid_hold", bus.o_fetch_valid, 1'b1);
        end
        check_eq("outstanding", (mem_addr_q.size() + int'(bus.o_fetch_valid)) <= MAX_OUT, 1'b1);
        // Advance the model by what happens at the coming edge.
        if (exp_dpc.size() != 0 && dr) begin
            void'(exp_dpc.pop_front()); void'(exp_dins.pop_front()); n_dec++;
        end
        if (rv && exp_rdy) begin
            a = mem_addr_q.pop_front(); g = mem_gen_q.pop_front();
            if (!stale) begin exp_dpc.push_back(a); exp_dins.push_back(instr_of(a)); end
        end
        if (bus.o_fetch_valid && fr && ar_seen) begin
            mem_addr_q.push_back(ar_held); mem_gen_q.push_back(ar_gen);
            ar_seen = 1'b0; n_ar++;
        end
        if (redir) begin
            exp_dpc.delete(); exp_dins.delete();
            redirect_cnt++; exp_pc = tgt & 32'hFFFF_FFFC;
        end
    endtask

    task automatic set_policy(input int fr, input int iv, input int dr, input int rd);
        p_frdy = fr; p_ivld = iv; p_drdy = dr; p_redir = rd;
    endtask

    initial begin
        bit found;
        rstn = 1'b0; n_dec = 0; seen_wrap = 1'b0; force_tgt = 32'h0;
        set_policy(100, 100, 100, 0);

        // Reset release with always-ready memory and decode: first request at cycle 2.
        do_reset();
        for (int i = 0; i < 30; i++) step();
        check_eq("first_fetch_cycle", first_valid, 2);

        // Memory stall with a redirect to 0x200 while 0x100 is held.
        do_reset();
        set_policy(0, 100, 100, 0);
        for (int i = 0; i < 10 && !ar_seen; i++) step();
        check_eq("stall_held_addr", bus.o_fetch_addr, RST_PC);
        step();
        force_redir = 1'b1; force_tgt = 32'h0000_0200; step(); force_redir = 1'b0;
        step(); step();
        set_policy(100, 100, 100, 0);
        for (int i = 0; i < 30; i++) step();

        // Responses withheld: outstanding limit stops issue.
        do_reset();
        set_policy(100, 0, 100, 0);
        for (int i = 0; i < 15; i++) step();
        check_eq("max_out_ar_count", n_ar, MAX_OUT);
        check_eq("max_out_no_valid", bus.o_fetch_valid, 1'b0);

        // Decode back-pressure with responses pending, then resume.
        set_policy(100, 100, 0, 0);
        for (int i = 0; i < 6; i++) step();
        check_eq("dec_stall_valid", bus.o_dec_valid, 1'b1);
        set_policy(100, 100, 100, 0);
        for (int i = 0; i < 20; i++) step();
        check_eq("resume_ar_count", n_ar > MAX_OUT, 1'b1);

        // Redirect to 0x303 in the same cycle as a valid response.
        set_policy(100, 0, 100, 0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = (mem_addr_q.size() != 0) && redirect_safe();
        end
        check_eq("redir_resp_setup", found, 1'b1);
        set_policy(100, 100, 100, 0);
        force_redir = 1'b1; force_tgt = 32'h0000_0303; step(); force_redir = 1'b0;
        step();
        check_eq("redir_resp_dec_clear", bus.o_dec_valid, 1'b0);
        for (int i = 0; i < 20; i++) step();

        // Redirect to the top word: fetch addresses wrap to zero.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = redirect_safe();
        end
        check_eq("wrap_setup", found, 1'b1);
        force_redir = 1'b1; force_tgt = 32'hFFFF_FFFC; step(); force_redir = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check_eq("wrap_seen", seen_wrap, 1'b1);

        // Randomized traffic, redirects included.
        do_reset();
        n_dec = 0;
        set_policy(70, 60, 70, 5);
        for (int i = 0; i < 3000; i++) step();
        check_eq("random_progress", n_dec > 100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the instruction-fetch datapath. Owns the program counter and issues word-aligned fetch requests to the fetch unit's fetch/instr handshakes.
- Tracks up to MAX_OUTSTANDING in-flight reads, tagged with PC and epoch, and discards stale responses after a branch/jump redirect.
- Presents each fetched instruction, with its PC, to decode through a one-entry registered valid/ready output stage.

Parameters:
XLEN, 32, address/PC width
IMDATALEN, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
MAX_OUTSTANDING, 2, max requests issued but not yet responded (>=1; tag FIFO depth)

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
o_fetch_valid  output  1  fetch request valid (to fetch unit)
i_fetch_ready  input  1  fetch request accepted
o_fetch_addr  output  XLEN  byte address of request
i_instr_valid  input  1  instruction response valid
o_instr_ready  output  1  response accept
i_instr_data  input  IMDATALEN  response data
i_redirect_valid  input  1  one-cycle pulse: branch/jump taken
i_redirect_pc  input  XLEN  redirect target (bits [1:0] ignored, forced 0)
o_dec_valid  output  1  instruction to decode valid
i_dec_ready  input  1  decode accepts
o_dec_instr  output  IMDATALEN  instruction
o_dec_pc  output  XLEN  PC of o_dec_instr

Behaviour:
- Reset (async, rstn=0):
  - pc=RESET_PC; AR register empty, so o_fetch_valid=0 and o_fetch_addr=RESET_PC.
  - Epoch bit=0; tag FIFO empty.
  - o_dec_valid=0, o_dec_instr=0, o_dec_pc=0, o_instr_ready=0; state=IDLE.
  - Reset mid-operation discards all in-flight state; late responses after reset are not the sequencer's concern.
- States:
  - IDLE: exactly one cycle after rstn deasserts, no issue; goes to RUN.
  - RUN: normal issue and retire.
  - No other states.
- AR register {ar_valid, ar_addr, ar_epoch} drives o_fetch_valid/o_fetch_addr.
  - Once o_fetch_valid=1, valid and addr are held stable until i_fetch_ready (AXI rule), including across a redirect.
- Issue:
  - In RUN, with no redirect this cycle, if (ar_valid=0 or AR handshake this cycle) and (FIFO count + ar_valid) < MAX_OUTSTANDING (registered values), load ar_addr=pc and ar_epoch=epoch, then pc=pc+4 (wraps modulo 2^XLEN).
  - Back-to-back issue gives one request per cycle.
- AR handshake (o_fetch_valid & i_fetch_ready) pushes {ar_addr, ar_epoch} into the tag FIFO.
- Response handling, with the FIFO head as tag:
  - o_instr_ready = FIFO non-empty & (head stale | o_dec_valid=0 | i_dec_ready).
  - A response is stale if head epoch != current epoch, or if i_redirect_valid=1 in the same cycle.
  - Each R handshake pops the head.
  - Non-stale response: loads o_dec_instr=i_instr_data, o_dec_pc=head PC, o_dec_valid=1 next cycle (latency 1).
  - Stale response: accepted and dropped.
- Decode stage: o_dec_valid clears on a decode handshake unless reloaded in the same cycle.
- Redirect, i_redirect_valid=1 at cycle N (priority over issue):
  - pc=i_redirect_pc & ~3, epoch toggles, o_dec_valid=0 at N+1.
  - No new AR load in cycle N; the first redirect-target request appears on o_fetch_addr at N+1 if the AR register is free.
  - A held old-epoch AR completes normally and its response is dropped.
  - Redirect while a redirect is still draining simply toggles epoch again; only the newest epoch survives.
  - Back-to-back redirects: the last one wins.
- Simultaneous push and pop on the FIFO keeps count unchanged. The FIFO never overflows, because issue is gated on count. A response with an empty FIFO is a protocol violation (bench assertion).

Test Plan:
- Reset release, RESET_PC=0x100, always-ready memory and decode -> fetch addrs 0x100, 0x104, 0x108 on consecutive cycles from cycle 2; decode sees matching pc/instr in order, 1 cycle after each response.
- Memory i_fetch_ready=0 for 5 cycles with a redirect to 0x200 during the stall -> o_fetch_addr holds 0x100 until accepted; that response is dropped; the next issued addr is 0x200 and decode's first pc after the redirect is 0x200.
- MAX_OUTSTANDING=2, responses withheld -> exactly 2 AR handshakes, then o_fetch_valid stays 0 until a response pops.
- i_dec_ready=0 for 4 cycles with a response pending -> o_instr_ready=0, o_dec_instr/o_dec_pc stable, no data lost; the order resumes when ready.
- Redirect in the same cycle as a valid response (redirect_pc=0x303) -> response dropped, o_dec_valid=0 next cycle, next fetch addr 0x300.
- Redirect to 0xFFFF_FFFC -> fetch addrs 0xFFFF_FFFC then 0x0000_0000.
